mpmc11_to_monitor: RTL and testbench

- Consumes the per-state timeout count from the mpmc11 timeout counter and the controller's current state.
- Declares a timeout when the count reaches a programmed threshold outside IDLE.
- Runs a recovery handshake with the controller state machine and escalates to a sticky fault after repeated consecutive timeouts.
- Keeps timeout statistics and captures the state in which the last timeout occurred, for status readback.

---
 rtl/mpmc11_to_monitor.sv | 137 +++++++++++++
 tb/tb_mpmc11_to_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mpmc11_to_monitor.sv
// Timeout monitor for the mpmc11 controller: detects per-state timeouts,
// drives the recovery handshake, escalates to a sticky fault and keeps stats.
package mpmc11_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACT   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    PRE   = 3'd4,
    REF   = 3'd5
  } mpmc11_state_t;
endpackage

module mpmc11_to_monitor
  import mpmc11_pkg::*;
#(
  parameter logic [15:0] TO_THRESH = 16'd500,
  parameter logic [3:0]  RETRY_MAX = 4'd3,
  parameter logic [7:0]  ACK_WAIT  = 8'd64
) (
  input  logic          clk,
  input  logic          rstn,
  input  mpmc11_state_t state,
  input  logic [15:0]   to_cnt,
  input  logic          xfer_done,
  input  logic          recover_ack,
  input  logic          fault_clr,
  input  logic          stat_clr,
  output logic          recover_req,
  output logic          to_pulse,
  output logic          fault,
  output logic [3:0]    retry_cnt,
  output logic [15:0]   timeout_count,
  output mpmc11_state_t last_to_state
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned ACK_W   = 8;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_REQ   = 2'd1;
  localparam logic [1:0] M_HOLD  = 2'd2;
  localparam logic [1:0] M_FAULT = 2'd3;

  localparam logic [CNT_W-1:0]   TC_MAX    = {CNT_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_SAT = {RETRY_W{1'b1}};
  localparam logic [ACK_W-1:0]   ACK_LAST  = ACK_W'(ACK_WAIT - 8'd1);

  logic [1:0]         m_q, m_d;
  logic [ACK_W-1:0]   ack_q, ack_d;
  logic               req_d, pulse_d, fault_d;
  logic [RETRY_W-1:0] retry_d, retry_inc;
  logic [CNT_W-1:0]   tc_d;
  mpmc11_state_t      last_d;
  logic               det;

  assign det = (to_cnt == TO_THRESH) && (state != IDLE) && (m_q == M_IDLE);

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q           <= M_IDLE;
      ack_q         <= '0;
      recover_req   <= 1'b0;
      to_pulse      <= 1'b0;
      fault         <= 1'b0;
      retry_cnt     <= '0;
      timeout_count <= '0;
      last_to_state <= IDLE;
    end else begin
      m_q           <= m_d;
      ack_q         <= ack_d;
      recover_req   <= req_d;
      to_pulse      <= pulse_d;
      fault         <= fault_d;
      retry_cnt     <= retry_d;
      timeout_count <= tc_d;
      last_to_state <= last_d;
    end
  end

  // Next state; clears are applied before the detection increments
  always_comb begin
    m_d       = m_q;
    ack_d     = '0;
    req_d     = recover_req;
    pulse_d   = 1'b0;
    fault_d   = fault;
    last_d    = last_to_state;
    retry_d   = (xfer_done && (m_q != M_FAULT)) ? '0 : retry_cnt;
    tc_d      = stat_clr ? '0 : timeout_count;
    retry_inc = (retry_d == RETRY_SAT) ? retry_d : retry_d + RETRY_W'(1);

    case (m_q)
      M_IDLE: begin
        if (det) begin
          pulse_d = 1'b1;
          last_d  = state;
          retry_d = retry_inc;
          if (tc_d != TC_MAX) tc_d = tc_d + CNT_W'(1);
          if (retry_inc >= RETRY_MAX) begin
            fault_d = 1'b1;
            m_d     = M_FAULT;
          end else begin
            req_d = 1'b1;
            m_d   = M_REQ;
          end
        end
      end
      M_REQ: begin
        if (recover_ack) begin
          req_d = 1'b0;
          m_d   = M_HOLD;
        end else if (ack_q == ACK_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          m_d     = M_FAULT;
        end else begin
          ack_d = ack_q + ACK_W'(1);
        end
      end
      M_HOLD: begin
        if (state == IDLE) m_d = M_IDLE;
      end
      M_FAULT: begin
        if (fault_clr) begin
          fault_d = 1'b0;
          retry_d = '0;
          m_d     = M_IDLE;
        end
      end
      default: m_d = M_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mpmc11_to_monitor.sv
// Directed bench for mpmc11_to_monitor with a detection scoreboard.
module tb_mpmc11_to_monitor;
  import mpmc11_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  mpmc11_state_t state;
  logic [15:0]   to_cnt;
  logic          xfer_done, recover_ack, fault_clr, stat_clr;
  logic          recover_req, to_pulse, fault;
  logic [3:0]    retry_cnt;
  logic [15:0]   timeout_count;
  mpmc11_state_t last_to_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0]   tc;
    mpmc11_state_t st;
    logic [3:0]    retry;
    logic          req;
    logic          flt;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] m_tc    = '0;
  logic [3:0]  m_retry = '0;

  mpmc11_to_monitor dut (
    .clk(clk), .rstn(rstn), .state(state), .to_cnt(to_cnt),
    .xfer_done(xfer_done), .recover_ack(recover_ack), .fault_clr(fault_clr),
    .stat_clr(stat_clr), .recover_req(recover_req), .to_pulse(to_pulse),
    .fault(fault), .retry_cnt(retry_cnt), .timeout_count(timeout_count),
    .last_to_state(last_to_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model of one detection
  task automatic model_push(input mpmc11_state_t st, input logic xd, input logic sc);
    exp_t e;
    if (xd) m_retry = '0;
    if (m_retry != 4'hF) m_retry = m_retry + 4'd1;
    if (sc) m_tc = '0;
    if (m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
    e.tc = m_tc; e.st = st; e.retry = m_retry;
    e.req = (m_retry < 4'd3);
    e.flt = !(m_retry < 4'd3);
    exp_q.push_back(e);
  endtask

  task automatic push_det(input mpmc11_state_t st, input logic xd, input logic sc);
    model_push(st, xd, sc);
    state = st; to_cnt = 16'd500; xfer_done = xd; stat_clr = sc;
    step();
    to_cnt = 16'd0; xfer_done = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic check_detect(input string tag);
    exp_t e;
    int n = 0;
    while (!to_pulse && n < 20) begin step(); n++; end
    chk({tag, "_pulse"}, 32'(to_pulse), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_tc"},    32'(timeout_count), 32'(e.tc));
    chk({tag, "_last"},  32'(last_to_state), 32'(e.st));
    chk({tag, "_retry"}, 32'(retry_cnt),     32'(e.retry));
    chk({tag, "_req"},   32'(recover_req),   32'(e.req));
    chk({tag, "_fault"}, 32'(fault),         32'(e.flt));
    step();
    chk({tag, "_pulse_1cyc"}, 32'(to_pulse), 32'd0);
  endtask

  task automatic ack_and_idle(input string tag);
    step();
    chk({tag, "_req_pre_ack"}, 32'(recover_req), 32'd1);
    recover_ack = 1'b1;
    step();
    recover_ack = 1'b0;
    chk({tag, "_req_post_ack"}, 32'(recover_req), 32'd0);
    state = IDLE;
    step();
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   32'(recover_req),   32'd0);
    chk({tag, "_pulse"}, 32'(to_pulse),      32'd0);
    chk({tag, "_fault"}, 32'(fault),         32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt),     32'd0);
    chk({tag, "_tc"},    32'(timeout_count), 32'd0);
    chk({tag, "_last"},  32'(last_to_state), 32'(IDLE));
  endtask

  initial begin
    int cnt;
    rstn = 1'b0; state = IDLE; to_cnt = '0;
    xfer_done = 1'b0; recover_ack = 1'b0; fault_clr = 1'b0; stat_clr = 1'b0;
    step();
    check_reset_vals("reset");
    rstn = 1'b1;
    step();

    // IDLE immunity
    to_cnt = 16'd500;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_no_pulse", 32'(to_pulse), 32'd0);
    end
    chk("idle_tc", 32'(timeout_count), 32'd0);
    chk("idle_retry", 32'(retry_cnt), 32'd0);
    to_cnt = '0;
    step();

    // Threshold hit via ramp
    state = READ;
    for (int v = 0; v <= 500; v++) begin
      to_cnt = 16'(v);
      if (v == 500) model_push(READ, 1'b0, 1'b0);
      step();
    end
    to_cnt = '0;
    check_detect("ramp");
    ack_and_idle("ramp");

    // Escalation
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    m_retry = '0;
    chk("xfer_clr_retry", 32'(retry_cnt), 32'd0);
    push_det(WRITE, 1'b0, 1'b0); check_detect("esc1"); ack_and_idle("esc1");
    push_det(ACT,   1'b0, 1'b0); check_detect("esc2"); ack_and_idle("esc2");
    push_det(PRE,   1'b0, 1'b0); check_detect("esc3");
    state = READ; to_cnt = 16'd500;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_no_pulse", 32'(to_pulse), 32'd0);
      chk("fault_no_req", 32'(recover_req), 32'd0);
    end
    chk("fault_tc_hold", 32'(timeout_count), 32'(m_tc));
    to_cnt = '0; state = IDLE;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    m_retry = '0;
    chk("fault_clr_fault", 32'(fault), 32'd0);
    chk("fault_clr_retry", 32'(retry_cnt), 32'd0);

    // Ack timeout
    push_det(WRITE, 1'b0, 1'b0);
    check_detect("ackto");
    cnt = 1;
    while (recover_req && cnt < 200) begin cnt++; step(); end
    chk("ackto_req_cycles", 32'(cnt), 32'd64);
    chk("ackto_fault", 32'(fault), 32'd1);
    chk("ackto_req_low", 32'(recover_req), 32'd0);
    state = IDLE;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    m_retry = '0;
    chk("ackto_clr", 32'(fault), 32'd0);

    // Simultaneous events
    push_det(READ, 1'b0, 1'b0); check_detect("sim1"); ack_and_idle("sim1");
    push_det(READ, 1'b0, 1'b0); check_detect("sim2"); ack_and_idle("sim2");
    push_det(WRITE, 1'b1, 1'b0); check_detect("xfer_det"); ack_and_idle("xfer_det");
    push_det(REF, 1'b0, 1'b1); check_detect("sclr_det");

    // Reset mid-REQ
    chk("pre_rst_req", 32'(recover_req), 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_rst_req", 32'(recover_req), 32'd0);
    @(negedge clk);
    check_reset_vals("rst_mid");
    state = IDLE;
    rstn = 1'b1;
    step();
    check_reset_vals("rst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
